spike_demux: RTL and testbench



---
 rtl/spike_demux.sv | 60 ++++++
 tb/tb_spike_demux.sv | 79 +++++++
 2 files changed

// File: rtl/spike_demux.sv
// spike_demux: routes one column's output to two time-multiplexed networks.
// It also replays each network's captured first-spike times while the other network owns the column.
module spike_demux #(
   parameter int Q  = 2,
   parameter int TW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         grst,
   input  logic [Q-1:0] spikes_in,
   output logic [Q-1:0] output_spikes1,
   output logic [Q-1:0] output_spikes2,
   output logic         slot_sel
);
   localparam logic [TW-1:0] TMAX = '1;
   logic [TW-1:0]             t_q, t_d;
   logic                      slot_q, slot_d;
   logic [1:0]                own;
   logic [1:0][Q-1:0]         valid_q, valid_d, out_q, out_d, set_v;
   logic [1:0][Q-1:0][TW-1:0] stamp_q, stamp_d;
   always_comb begin
      t_d = grst ? '0 : (t_q == TMAX ? t_q : t_q + 1'b1);
      slot_d = slot_q ^ grst;
      own = {slot_q, ~slot_q};
      valid_d = valid_q;
      stamp_d = stamp_q;
      set_v = '0;
      // own[k] selects live spikes; otherwise replay the stored first-spike time
      for (int k = 0; k < 2; k++) begin
         for (int q = 0; q < Q; q++) begin
            set_v[k][q] = own[k] ? spikes_in[q] : (valid_q[k][q] && t_q == stamp_q[k][q]);
            if (grst && !own[k]) begin
               valid_d[k][q] = 1'b0;
            end else if (!grst && own[k] && spikes_in[q] && !valid_q[k][q]) begin
               valid_d[k][q] = 1'b1;
               stamp_d[k][q] = t_q;
            end
         end
      end
      out_d = grst ? '0 : (out_q | set_v);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q <= '0;
         slot_q <= 1'b0;
         valid_q <= '0;
         stamp_q <= '0;
         out_q <= '0;
      end else begin
         t_q <= t_d;
         slot_q <= slot_d;
         valid_q <= valid_d;
         stamp_q <= stamp_d;
         out_q <= out_d;
      end
   end
   assign output_spikes1 = out_q[0];
   assign output_spikes2 = out_q[1];
   assign slot_sel = slot_q;
endmodule

// File: tb/tb_spike_demux.sv
// tb_spike_demux: directed checks of live, capture, replay, saturation and reset behaviour.
module tb_spike_demux;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       grst = 1'b0;
   logic [1:0] spikes_in = '0;
   logic [1:0] output_spikes1, output_spikes2;
   logic       slot_sel;
   int         n_chk = 0;
   int         n_err = 0;
   spike_demux #(.Q(2), .TW(4)) dut (
      .clk(clk), .rst(rst), .grst(grst), .spikes_in(spikes_in),
      .output_spikes1(output_spikes1), .output_spikes2(output_spikes2), .slot_sel(slot_sel)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask
   // Cycle i of a gamma has t = min(i,15); grst is driven in the last cycle.
   task automatic gamma(input string tag, input int len, input int s_from, input int s_to,
                        input logic [1:0] s_val, input logic sl,
                        input int e1_from, input logic [1:0] e1_val,
                        input int e2_from, input logic [1:0] e2_val);
      for (int i = 0; i < len; i++) begin
         chk({tag, " slot"}, {1'b0, slot_sel}, {1'b0, sl});
         chk($sformatf("%s out1 i=%0d", tag, i), output_spikes1, i >= e1_from ? e1_val : 2'b00);
         chk($sformatf("%s out2 i=%0d", tag, i), output_spikes2, i >= e2_from ? e2_val : 2'b00);
         spikes_in = (i >= s_from && i < s_to) ? s_val : 2'b00;
         grst = (i == len - 1);
         @(posedge clk);
         #1;
      end
      grst = 1'b0;
      spikes_in = '0;
   endtask
   initial begin
      #2 rst = 1'b1;
      #1;
      chk("reset out1", output_spikes1, 2'b00);
      chk("reset out2", output_spikes2, 2'b00);
      chk("reset slot", {1'b0, slot_sel}, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      gamma("g1 live", 10, 3, 9, 2'b01, 1'b0, 4, 2'b01, 99, 2'b00);
      gamma("g2 replay+live", 10, 5, 9, 2'b10, 1'b1, 4, 2'b01, 6, 2'b10);
      gamma("g3 recapture", 10, 0, 0, 2'b00, 1'b0, 99, 2'b00, 6, 2'b10);
      gamma("g4 silent", 10, 0, 0, 2'b00, 1'b1, 99, 2'b00, 99, 2'b00);
      gamma("g5 sat live", 20, 18, 19, 2'b01, 1'b0, 19, 2'b01, 99, 2'b00);
      gamma("g6 sat replay", 20, 0, 0, 2'b00, 1'b1, 16, 2'b01, 99, 2'b00);
      gamma("g7 grst spike", 8, 7, 8, 2'b11, 1'b0, 99, 2'b00, 99, 2'b00);
      gamma("g8 no capture", 8, 0, 0, 2'b00, 1'b1, 99, 2'b00, 99, 2'b00);
      gamma("g9 both live", 6, 2, 5, 2'b11, 1'b0, 3, 2'b11, 99, 2'b00);
      spikes_in = 2'b10;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre-rst out2", output_spikes2, 2'b10);
      chk("pre-rst out1", output_spikes1, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk("mid-rst out1", output_spikes1, 2'b00);
      chk("mid-rst out2", output_spikes2, 2'b00);
      chk("mid-rst slot", {1'b0, slot_sel}, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      spikes_in = '0;
      gamma("g10 post-rst", 6, 0, 0, 2'b00, 1'b0, 99, 2'b00, 99, 2'b00);
      gamma("g11 post-rst", 6, 0, 0, 2'b00, 1'b1, 99, 2'b00, 99, 2'b00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
